onchip_ram_dualport: RTL and testbench

ONCHIP_RAM_DUALPORT -- requirements
Module: onchip_ram_dualport

---
 rtl/onchip_ram_pkg.sv | 16 +
 rtl/onchip_ram_rd_pipe.sv | 52 +++++
 rtl/onchip_ram_dualport.sv | 104 ++++++++++
 tb/tb_onchip_ram_dualport.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared constants and helpers for the on-chip dual-port RAM family.
package onchip_ram_pkg;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 2;

  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_ADDR_W       = 13;
  localparam int unsigned DEF_DEPTH        = 8192;
  localparam int unsigned DEF_READ_LATENCY = 1;

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_rd_pipe.sv
// Read response pipeline: one or two registered stages of data and valid.
module onchip_ram_rd_pipe
  import onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rd_accept,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] stg1_data;
  logic              stg1_valid;

  // Data only loads on a real response so the output holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg1_data  <= '0;
      stg1_valid <= 1'b0;
    end else if (en) begin
      stg1_valid <= rd_accept;
      if (rd_accept) stg1_data <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] stg2_data;
    logic              stg2_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg2_data  <= '0;
        stg2_valid <= 1'b0;
      end else if (en) begin
        stg2_valid <= stg1_valid;
        if (stg1_valid) stg2_data <= stg1_data;
      end
    end

    assign rd_data  = stg2_data;
    assign rd_valid = stg2_valid;
  end else begin : g_lat1
    assign rd_data  = stg1_data;
    assign rd_valid = stg1_valid;
  end

endmodule

// File: rtl/onchip_ram_dualport.sv
// True dual-port on-chip RAM with byte enables, global clock enable and
// a configurable 1- or 2-cycle read latency on both ports.
module onchip_ram_dualport
  import onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter              INIT_FILE    = "onchip_ram_dualport.hex"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reset_req,
  input  logic                   clken,

  input  logic [ADDR_W-1:0]      s1_address,
  input  logic                   s1_chipselect,
  input  logic                   s1_read,
  input  logic                   s1_write,
  input  logic [DATA_W/8-1:0]    s1_byteenable,
  input  logic [DATA_W-1:0]      s1_writedata,
  output logic [DATA_W-1:0]      s1_readdata,
  output logic                   s1_readdatavalid,

  input  logic [ADDR_W-1:0]      s2_address,
  input  logic                   s2_chipselect,
  input  logic                   s2_read,
  input  logic                   s2_write,
  input  logic [DATA_W/8-1:0]    s2_byteenable,
  input  logic [DATA_W-1:0]      s2_writedata,
  output logic [DATA_W-1:0]      s2_readdata,
  output logic                   s2_readdatavalid
);

  localparam int unsigned NB    = byte_lanes(DATA_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX || (DATA_W % 8) != 0 ||
      64'(DEPTH) > (64'(1) << ADDR_W) || DEPTH == 0) begin : g_bad_param
    $error("onchip_ram_dualport: illegal DATA_W/READ_LATENCY/DEPTH (init file %s)", INIT_FILE);
  end

  logic              en;
  logic              s1_in_range, s2_in_range;
  logic              s1_rd_acc, s2_rd_acc;
  logic              s1_wr_en, s2_wr_en;
  logic [IDX_W-1:0]  s1_idx, s2_idx;
  logic [DATA_W-1:0] s1_rd_word, s2_rd_word;

  assign en = clken & ~reset_req;

  assign s1_in_range = ({1'b0, s1_address} < (ADDR_W+1)'(DEPTH));
  assign s2_in_range = ({1'b0, s2_address} < (ADDR_W+1)'(DEPTH));
  assign s1_idx      = IDX_W'(s1_address);
  assign s2_idx      = IDX_W'(s2_address);

  // A write on the same port beats a read; out-of-range writes are dropped.
  assign s1_rd_acc = en & s1_chipselect & s1_read & ~s1_write;
  assign s2_rd_acc = en & s2_chipselect & s2_read & ~s2_write;
  assign s1_wr_en  = en & s1_chipselect & s1_write & s1_in_range;
  assign s2_wr_en  = en & s2_chipselect & s2_write & s2_in_range;

  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [DEPTH];

  // s1 is applied last so it owns any byte lane both ports enable.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (s2_wr_en && s2_byteenable[b]) mem[s2_idx][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      if (s1_wr_en && s1_byteenable[b]) mem[s1_idx][b*8 +: 8] <= s1_writedata[b*8 +: 8];
    end
  end

  assign s1_rd_word = s1_in_range ? mem[s1_idx] : '0;
  assign s2_rd_word = s2_in_range ? mem[s2_idx] : '0;

  onchip_ram_rd_pipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_s1_pipe (
    .clk       (clk),
    .rst       (reset),
    .en        (en),
    .rd_accept (s1_rd_acc),
    .rd_word   (s1_rd_word),
    .rd_data   (s1_readdata),
    .rd_valid  (s1_readdatavalid)
  );

  onchip_ram_rd_pipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_s2_pipe (
    .clk       (clk),
    .rst       (reset),
    .en        (en),
    .rd_accept (s2_rd_acc),
    .rd_word   (s2_rd_word),
    .rd_data   (s2_readdata),
    .rd_valid  (s2_readdatavalid)
  );

endmodule

// File: tb/tb_onchip_ram_dualport.sv
// Bench for onchip_ram_dualport: latency-1 and latency-2 instances share
// stimulus and are checked against one array-and-history reference model.
module tb_onchip_ram_dualport;

  localparam int unsigned AW    = 13;
  localparam int          DEPTH = 8000;

  logic clk = 1'b0;
  logic reset, reset_req, clken;
  logic [AW-1:0] addr [2];
  logic          cs   [2];
  logic          rd   [2];
  logic          wr   [2];
  logic [3:0]    be   [2];
  logic [31:0]   wd   [2];
  logic [31:0]   rdat [2][2];
  logic          rvld [2][2];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: memory contents plus a history of accepted reads per enabled edge.
  logic [31:0] mem_m [int];
  bit          acc_v [2][8192];
  logic [31:0] acc_d [2][8192];
  int          k     = 0;
  int          rst_k = 0;
  logic        exp_vld [2][2];
  logic [31:0] exp_dat [2][2];

  always #5 clk = ~clk;

  onchip_ram_dualport #(
    .DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_FILE("")
  ) u_lat1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]),
    .s1_readdata(rdat[0][0]), .s1_readdatavalid(rvld[0][0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]),
    .s2_readdata(rdat[0][1]), .s2_readdatavalid(rvld[0][1])
  );

  onchip_ram_dualport #(
    .DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .INIT_FILE("")
  ) u_lat2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]),
    .s1_readdata(rdat[1][0]), .s1_readdatavalid(rvld[1][0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]),
    .s2_readdata(rdat[1][1]), .s2_readdatavalid(rvld[1][1])
  );

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; be[p] = '0; wd[p] = '0;
    end
  endtask

  task automatic do_wr(input int p, input int a, input logic [31:0] d, input logic [3:0] b);
    addr[p] = AW'(a); cs[p] = 1'b1; rd[p] = 1'b0; wr[p] = 1'b1; be[p] = b; wd[p] = d;
  endtask

  task automatic do_rd(input int p, input int a);
    addr[p] = AW'(a); cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0; be[p] = '0; wd[p] = '0;
  endtask

  task automatic model_reset();
    rst_k = k;
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 2; p++) begin
        exp_vld[l][p] = 1'b0;
        exp_dat[l][p] = 32'h0;
      end
  endtask

  // One clock edge: update the model from the inputs present at the edge, then settle.
  task automatic tick();
    int j;
    int a;
    logic [31:0] w;
    @(posedge clk);
    if (!reset && clken && !reset_req) begin
      k++;
      for (int p = 0; p < 2; p++) begin
        a = int'(addr[p]);
        acc_v[p][k] = cs[p] && rd[p] && !wr[p];
        acc_d[p][k] = (a < DEPTH && mem_m.exists(a)) ? mem_m[a] : 32'h0;
      end
      for (int p = 1; p >= 0; p--) begin
        a = int'(addr[p]);
        if (cs[p] && wr[p] && a < DEPTH) begin
          w = mem_m.exists(a) ? mem_m[a] : 32'h0;
          for (int b = 0; b < 4; b++) if (be[p][b]) w[b*8 +: 8] = wd[p][b*8 +: 8];
          mem_m[a] = w;
        end
      end
      // Latency L delivers the read accepted L-1 enabled edges ago.
      for (int l = 0; l < 2; l++)
        for (int p = 0; p < 2; p++) begin
          j = k - l;
          exp_vld[l][p] = (j > rst_k) && acc_v[p][j];
          if (exp_vld[l][p]) exp_dat[l][p] = acc_d[p][j];
        end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    idle();
    tick();
    tick();
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 2; p++) begin
        n_vec++;
        if (rvld[l][p] !== 1'b0) begin
          n_miss++; $display("FAIL reset_vld lat%0d s%0d: got %b want 0", l + 1, p + 1, rvld[l][p]);
        end
        n_vec++;
        if (rdat[l][p] !== 32'h0) begin
          n_miss++; $display("FAIL reset_dat lat%0d s%0d: got %h want 0", l + 1, p + 1, rdat[l][p]);
        end
      end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    idle(); do_wr(0, 5, 32'hDEADBEEF, 4'hF); tick();
    idle(); do_rd(0, 5); tick();
    n_vec++;
    if (rvld[0][0] !== 1'b1 || rdat[0][0] !== 32'hDEADBEEF) begin
      n_miss++; $display("FAIL wr_rd_lat1: got v=%b d=%h want v=1 d=deadbeef", rvld[0][0], rdat[0][0]);
    end
    n_vec++;
    if (rvld[1][0] !== 1'b0) begin
      n_miss++; $display("FAIL wr_rd_lat2_early: got v=%b want 0", rvld[1][0]);
    end
    idle(); tick();
    n_vec++;
    if (rvld[0][0] !== 1'b0 || rdat[0][0] !== 32'hDEADBEEF) begin
      n_miss++; $display("FAIL wr_rd_lat1_hold: got v=%b d=%h want v=0 d=deadbeef", rvld[0][0], rdat[0][0]);
    end
    n_vec++;
    if (rvld[1][0] !== 1'b1 || rdat[1][0] !== 32'hDEADBEEF) begin
      n_miss++; $display("FAIL wr_rd_lat2: got v=%b d=%h want v=1 d=deadbeef", rvld[1][0], rdat[1][0]);
    end
  endtask

  task automatic test_byte_enable();
    idle(); do_wr(1, 5, 32'h000000AA, 4'b0001); tick();
    idle(); do_rd(1, 5); tick();
    n_vec++;
    if (rvld[1][1] !== 1'b0 || rvld[0][1] !== 1'b1 || rdat[0][1] !== 32'hDEADBEAA) begin
      n_miss++; $display("FAIL be_s2_first: got v2=%b v1=%b d1=%h want 0 1 deadbeaa", rvld[1][1], rvld[0][1], rdat[0][1]);
    end
    idle(); tick();
    n_vec++;
    if (rvld[1][1] !== 1'b1 || rdat[1][1] !== 32'hDEADBEAA) begin
      n_miss++; $display("FAIL be_s2_lat2: got v=%b d=%h want v=1 d=deadbeaa", rvld[1][1], rdat[1][1]);
    end
  endtask

  task automatic test_write_collision();
    idle(); do_wr(0, 9, 32'h0, 4'hF); tick();
    idle(); do_wr(0, 9, 32'h11111111, 4'b0011); do_wr(1, 9, 32'h22222222, 4'b0110); tick();
    idle(); do_rd(0, 9); tick();
    n_vec++;
    if (rvld[0][0] !== 1'b1 || rdat[0][0] !== 32'h00221111) begin
      n_miss++; $display("FAIL wr_collision: got v=%b d=%h want v=1 d=00221111", rvld[0][0], rdat[0][0]);
    end
  endtask

  task automatic test_read_during_write();
    idle(); do_wr(0, 3, 32'hCAFEF00D, 4'hF); tick();
    idle(); do_rd(0, 3); do_wr(1, 3, 32'h12345678, 4'hF); tick();
    n_vec++;
    if (rvld[0][0] !== 1'b1 || rdat[0][0] !== 32'hCAFEF00D) begin
      n_miss++; $display("FAIL rdw_old: got v=%b d=%h want v=1 d=cafef00d", rvld[0][0], rdat[0][0]);
    end
    idle(); do_rd(0, 3); tick();
    n_vec++;
    if (rvld[0][0] !== 1'b1 || rdat[0][0] !== 32'h12345678) begin
      n_miss++; $display("FAIL rdw_new: got v=%b d=%h want v=1 d=12345678", rvld[0][0], rdat[0][0]);
    end
  endtask

  task automatic test_out_of_range();
    idle(); do_wr(0, 8100, 32'hFFFFFFFF, 4'hF); tick();
    idle(); do_rd(0, 8100); tick();
    n_vec++;
    if (rvld[0][0] !== 1'b1 || rdat[0][0] !== 32'h0) begin
      n_miss++; $display("FAIL oor_read: got v=%b d=%h want v=1 d=0", rvld[0][0], rdat[0][0]);
    end
    idle(); tick();
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] pd [4];
    logic [31:0] cap [2][8];
    int          ncap [2];
    int          ra  [8] = '{20, 21, 22, 22, 22, 23, -1, -1};
    bit          ce  [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      pd[i] = $urandom();
      idle(); do_wr(0, 20 + i, pd[i], 4'hF); tick();
    end
    ncap[0] = 0; ncap[1] = 0;
    for (int s = 0; s < 8; s++) begin
      idle();
      if (ra[s] >= 0) do_rd(0, ra[s]);
      clken = ce[s];
      tick();
      for (int l = 0; l < 2; l++) begin
        if (ce[s] && rvld[l][0] === 1'b1 && ncap[l] < 8) begin
          cap[l][ncap[l]] = rdat[l][0];
          ncap[l]++;
        end
        for (int p = 0; p < 2; p++) begin
          n_vec++;
          if (rvld[l][p] !== exp_vld[l][p]) begin
            n_miss++; $display("FAIL stall_vld step%0d lat%0d s%0d: got %b want %b", s, l + 1, p + 1, rvld[l][p], exp_vld[l][p]);
          end
          n_vec++;
          if (rdat[l][p] !== exp_dat[l][p]) begin
            n_miss++; $display("FAIL stall_dat step%0d lat%0d s%0d: got %h want %h", s, l + 1, p + 1, rdat[l][p], exp_dat[l][p]);
          end
        end
      end
    end
    clken = 1'b1;
    for (int l = 0; l < 2; l++) begin
      n_vec++;
      if (ncap[l] !== 4) begin
        n_miss++; $display("FAIL stall_pulses lat%0d: got %0d want 4", l + 1, ncap[l]);
      end
      for (int i = 0; i < 4 && i < ncap[l]; i++) begin
        n_vec++;
        if (cap[l][i] !== pd[i]) begin
          n_miss++; $display("FAIL stall_order lat%0d #%0d: got %h want %h", l + 1, i, cap[l][i], pd[i]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] v;
    v = $urandom();
    idle(); do_wr(1, 40, v, 4'hF); tick();
    idle(); do_rd(0, 40); tick();
    reset = 1'b1;
    idle();
    #1;
    model_reset();
    for (int l = 0; l < 2; l++) begin
      n_vec++;
      if (rvld[l][0] !== 1'b0 || rdat[l][0] !== 32'h0) begin
        n_miss++; $display("FAIL inflight_rst lat%0d: got v=%b d=%h want v=0 d=0", l + 1, rvld[l][0], rdat[l][0]);
      end
    end
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (rvld[1][0] !== 1'b0 || rdat[1][0] !== 32'h0) begin
        n_miss++; $display("FAIL inflight_ghost cyc%0d: got v=%b d=%h want v=0 d=0", c, rvld[1][0], rdat[1][0]);
      end
    end
    do_rd(0, 40); tick();
    n_vec++;
    if (rvld[0][0] !== 1'b1 || rdat[0][0] !== v) begin
      n_miss++; $display("FAIL inflight_keep_lat1: got v=%b d=%h want v=1 d=%h", rvld[0][0], rdat[0][0], v);
    end
    idle(); tick();
    n_vec++;
    if (rvld[1][0] !== 1'b1 || rdat[1][0] !== v) begin
      n_miss++; $display("FAIL inflight_keep_lat2: got v=%b d=%h want v=1 d=%h", rvld[1][0], rdat[1][0], v);
    end
  endtask

  task automatic test_random();
    int a;
    for (int i = 0; i < 16; i++) begin
      idle();
      do_wr(0, 2 * i, $urandom(), 4'hF);
      do_wr(1, 2 * i + 1, $urandom(), 4'hF);
      tick();
    end
    for (int c = 0; c < 400; c++) begin
      clken     = ($urandom_range(0, 7) != 0);
      reset_req = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < 2; p++) begin
        a = ($urandom_range(0, 4) == 0) ? DEPTH + int'($urandom_range(0, 191)) : int'($urandom_range(0, 31));
        addr[p] = AW'(a);
        cs[p]   = ($urandom_range(0, 3) != 0);
        rd[p]   = 1'($urandom());
        wr[p]   = 1'($urandom());
        be[p]   = 4'($urandom());
        wd[p]   = $urandom();
      end
      tick();
      for (int l = 0; l < 2; l++)
        for (int p = 0; p < 2; p++) begin
          n_vec++;
          if (rvld[l][p] !== exp_vld[l][p]) begin
            n_miss++; $display("FAIL rand_vld cyc%0d lat%0d s%0d: got %b want %b", c, l + 1, p + 1, rvld[l][p], exp_vld[l][p]);
          end
          n_vec++;
          if (rdat[l][p] !== exp_dat[l][p]) begin
            n_miss++; $display("FAIL rand_dat cyc%0d lat%0d s%0d: got %h want %h", c, l + 1, p + 1, rdat[l][p], exp_dat[l][p]);
          end
        end
    end
    clken = 1'b1; reset_req = 1'b0; idle();
  endtask

  initial begin
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_write_collision();
    test_read_during_write();
    test_out_of_range();
    test_back_to_back_stall();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
